// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// STATUS bit positions and register offsets from BASE_ADDR.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txState_t;

  localparam int STATUS_BUSY  = 0;
  localparam int STATUS_FULL  = 1;
  localparam int STATUS_OVF   = 2;
  localparam int STATUS_EMPTY = 3;

  localparam logic [31:0] OFFSET_TX_DATA = 32'd0;
  localparam logic [31:0] OFFSET_STATUS  = 32'd4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with synchronous push/pop, full/empty flags and occupancy count.
// A push while full is accepted only if a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [7:0]                   pushData,
  input  logic                         pop,
  output logic [7:0]                   popData,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Sized to the pointer range so every pointer value indexes a real entry.
  logic [7:0]       mem [1 << PTR_W];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  // NOTE: storage is not reset; the pointers and count define validity, and
  // leaving the array unreset lets it map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TX_DATA at BASE_ADDR, STATUS at +4.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH buffer; otherwise one holding register.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address_i,
  input  logic [31:0] WriteData_i,
  input  logic        MemWrite_i,
  output logic [31:0] ReadData_o,
  output logic        sel_o,
  output logic        tx_o,
  output logic        busy_o
);

`ifdef UART_TX_FIFO_EN
  localparam int FIFO_LEN = FIFO_DEPTH;
`else
  // FIFO_DEPTH has no effect in this build; a single holding register is used.
  localparam int FIFO_LEN = 1 + 0 * FIFO_DEPTH;
`endif
  localparam int CNT_W  = $clog2(FIFO_LEN + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  txState_t          state;
  logic [BAUD_W-1:0] baudCnt;
  logic [2:0]        bitCnt;
  logic [7:0]        shiftReg;
  logic              txReg;
  logic              overflow;

  logic              dataHit, statusHit, dataWrite, statusWrite;
  logic              baudLast, fifoPop, fifoFull, fifoEmpty;
  logic [7:0]        fifoData;
  logic [CNT_W-1:0]  fifoCount;
  logic [3:0]        status;
  logic              unusedBits;

  assign dataHit     = (Address_i == BASE_ADDR + OFFSET_TX_DATA);
  assign statusHit   = (Address_i == BASE_ADDR + OFFSET_STATUS);
  assign dataWrite   = MemWrite_i && dataHit;
  assign statusWrite = MemWrite_i && statusHit;
  assign baudLast    = (baudCnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign fifoPop     = !fifoEmpty && ((state == IDLE) || (state == STOP && baudLast));
  assign unusedBits  = ^{WriteData_i[31:8], fifoCount};

  uart_tx_fifo #(.DEPTH(FIFO_LEN)) txFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (dataWrite),
    .pushData (WriteData_i[7:0]),
    .pop      (fifoPop),
    .popData  (fifoData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    status               = '0;
    status[STATUS_BUSY]  = busy_o;
    status[STATUS_FULL]  = fifoFull;
    status[STATUS_OVF]   = overflow;
    status[STATUS_EMPTY] = fifoEmpty;
  end

  assign ReadData_o = statusHit ? {28'b0, status} : 32'b0;
  assign sel_o      = dataHit || statusHit;
  assign tx_o       = txReg;
  assign busy_o     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset)             overflow <= 1'b0;
    else if (statusWrite)  overflow <= 1'b0;
    else if (dataWrite && fifoFull && !fifoPop) overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      txReg    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (fifoPop) begin
            state    <= START;
            shiftReg <= fifoData;
            txReg    <= 1'b0;
            baudCnt  <= '0;
          end
        end
        START: begin
          if (baudLast) begin
            state   <= DATA;
            baudCnt <= '0;
            bitCnt  <= '0;
            txReg   <= shiftReg[0];
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        DATA: begin
          if (baudLast) begin
            baudCnt <= '0;
            bitCnt  <= bitCnt + 1'b1;
            if (bitCnt == 3'd7) begin
              state <= STOP;
              txReg <= 1'b1;
            end else begin
              shiftReg <= shiftReg >> 1;
              txReg    <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        STOP: begin
          if (baudLast) begin
            baudCnt <= '0;
            // Back-to-back frames start directly from STOP with no idle gap.
            if (fifoPop) begin
              state    <= START;
              shiftReg <= fifoData;
              txReg    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio at CLKS_PER_BIT=4: a queue-based frame model predicts
// tx_o, busy_o, sel_o and ReadData_o every cycle under directed and random traffic.
module tb_uart_tx_mmio;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h1001_0000;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [31:0] readData;
  logic        sel, tx, busy;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model: pending bytes, current frame byte and position in frame.
  logic [7:0] mQ[$];
  logic [7:0] mCur;
  bit         mActive;
  int         mPos;
  bit         mOvf;

  uart_tx_mmio #(.CLKS_PER_BIT(N), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .Address_i   (addr),
    .WriteData_i (wdata),
    .MemWrite_i  (we),
    .ReadData_o  (readData),
    .sel_o       (sel),
    .tx_o        (tx),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge();
    bit pop;
    if (reset) begin
      mQ.delete();
      mActive = 0;
      mPos    = 0;
      mOvf    = 0;
      return;
    end
    pop = (mQ.size() > 0) && (!mActive || mPos == 10 * N - 1);
    if (mActive) begin
      mPos++;
      if (mPos == 10 * N) mActive = 0;
    end
    if (pop) begin
      mCur    = mQ.pop_front();
      mActive = 1;
      mPos    = 0;
    end
    if (we && addr == BASE) begin
      if (mQ.size() < DEPTH) mQ.push_back(wdata[7:0]);
      else mOvf = 1;
    end
    if (we && addr == BASE + 4) mOvf = 0;
  endtask

  function automatic logic expTx();
    if (!mActive)      return 1'b1;
    if (mPos < N)      return 1'b0;
    if (mPos < 9 * N)  return mCur[mPos / N - 1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] expStatus();
    return {28'b0, mQ.size() == 0, mOvf, mQ.size() == DEPTH, mActive};
  endfunction

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    check("tx_o", tx, expTx());
    check("busy_o", busy, mActive);
    check("sel_o", sel, (addr == BASE) || (addr == BASE + 4));
    check("ReadData_o", readData, (addr == BASE + 4) ? expStatus() : 32'h0);
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
    addr  = '0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((mActive || mQ.size() > 0) && n < limit) begin
      step();
      n++;
    end
    check("drain_timeout", n < limit, 1'b1);
  endtask

  initial begin
    int frameLen;
    int n;

    // Reset, then read STATUS: only EMPTY set.
    repeat (3) step();
    reset = 1'b0;
    addr  = BASE + 4;
    step();
    check("reset_status", readData, 32'h8);
    check("reset_tx", tx, 1'b1);
    check("reset_sel", sel, 1'b1);

    // Single frame 0x55; busy must drop exactly one frame after the pop edge.
    busWrite(BASE, 32'h55);
    frameLen = 0;
    while (busy !== 1'b0 || frameLen == 0) begin
      step();
      frameLen++;
      if (frameLen > 100) break;
    end
    check("frame_len", frameLen, 10 * N + 1);

    // A few random single bytes with random gaps.
    for (int i = 0; i < 4; i++) begin
      busWrite(BASE, $urandom);
      repeat ($urandom_range(0, 60)) step();
    end
    drain(500);

    // Six back-to-back writes: the last overflows (earlier ones too without a FIFO).
    for (int i = 1; i <= 6; i++) busWrite(BASE, i);
    addr = BASE + 4;
    step();
    check("ovf_set", readData[2], 1'b1);
    drain(600);

    // Writing STATUS clears only the overflow bit.
    busWrite(BASE + 4, $urandom);
    addr = BASE + 4;
    step();
    check("ovf_cleared", readData, 32'h8);

    // Random mix of data writes, status writes, stray addresses and reads.
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 3)       busWrite(BASE, $urandom);
      else if (r == 3) busWrite(BASE + 4, $urandom);
      else if (r == 4) busWrite(BASE + 8, $urandom);
      else begin
        addr = (r < 7) ? BASE + 4 : $urandom;
        step();
      end
    end
    drain(1000);

    // Reset during DATA bit 3 with more bytes queued: frame aborts, queue is lost.
    busWrite(BASE, 32'hA5);
    busWrite(BASE, 32'h3C);
    busWrite(BASE, 32'hC3);
    n = 0;
    while (!(mActive && mPos == 4 * N + 1) && n < 100) begin
      step();
      n++;
    end
    check("bit3_timeout", n < 100, 1'b1);
    reset = 1'b1;
    step();
    check("abort_tx", tx, 1'b1);
    reset = 1'b0;
    addr  = BASE + 4;
    repeat (60) step();
    check("abort_status", readData, 32'h8);

    // Unmapped address: no frame, no select, no readback.
    busWrite(BASE + 8, 32'h5A);
    addr = BASE + 8;
    repeat (50) step();
    check("unmapped_sel", sel, 1'b0);
    check("unmapped_rd", readData, 32'h0);
    check("unmapped_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
